// File: rtl/selftest_pkg.sv
// Shared types and CRC helper for the SAP-1.5 self-test sequencer.
package selftest_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_VERIFY,
      ST_CPURST,
      ST_RUN,
      ST_CHECK,
      ST_DONE
   } selftest_state_t;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   // MSB-first CRC-8 over one byte.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/selftest_cycle_timer.sv
// Saturating cycle counter; `last` flags the enabled cycle that reaches LIMIT.
module selftest_cycle_timer #(
   parameter int LIMIT = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         enable,
   output logic [$clog2(LIMIT+1)-1:0]   count,
   output logic                         last
);

   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIMIT_V = W'(LIMIT);
   localparam logic [W-1:0] LAST_V  = W'(LIMIT - 1);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && count != LIMIT_V) begin
         count <= count + 1'b1;
      end
   end

   assign last = enable && (count == LAST_V);

endmodule

// File: rtl/selftest_sequencer.sv
// Load / reset / run-until-halt / check sequencer for the SAP-1.5 computer.
// Optional RAM readback verification is enabled by defining SELFTEST_READBACK_EN.
module selftest_sequencer
   import selftest_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 4,
   parameter int MAX_CYCLES   = 50,
   parameter int RESET_CYCLES = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [DATA_WIDTH-1:0]             expected,
   input  logic                              ld_valid,
   output logic                              ld_ready,
   input  logic [DATA_WIDTH-1:0]             ld_data,
   input  logic                              ld_last,
   output logic                              ram_we,
   output logic [ADDR_WIDTH-1:0]             ram_addr,
   output logic [DATA_WIDTH-1:0]             ram_wdata,
   input  logic [DATA_WIDTH-1:0]             ram_rdata,
   output logic                              cpu_reset,
   input  logic                              cpu_halt,
   input  logic [DATA_WIDTH-1:0]             probe,
   output logic                              busy,
   output logic                              done,
   output logic                              pass,
   output logic                              timeout,
   output logic                              load_err,
   output logic [$clog2(MAX_CYCLES+1)-1:0]   cycles,
   output logic [DATA_WIDTH-1:0]             captured
);

   localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
`ifdef SELFTEST_READBACK_EN
   localparam selftest_state_t POST_LOAD = ST_VERIFY;
   localparam int NBYTES = (DATA_WIDTH + 7) / 8;
`else
   localparam selftest_state_t POST_LOAD = ST_CPURST;
`endif

   selftest_state_t state, next_state;

   logic                  start_accept;
   logic                  xfer;
   logic                  hold_last;
   logic                  run_last;
   logic [HOLD_W-1:0]     hold_count;
   logic [DATA_WIDTH-1:0] expected_q;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] last_addr;
   logic                  unused_sig;

`ifdef SELFTEST_READBACK_EN
   logic [7:0]            crc_wr;
   logic [7:0]            crc_rd;
   logic [7:0]            crc_rd_next;
   logic                  crc_match;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  issuing;
   logic                  rd_vld_p0, rd_vld_p1;
   logic                  rd_last_p0, rd_last_p1;
   logic                  load_err_q;

   function automatic logic [7:0] crc_word(input logic [7:0] crc, input logic [DATA_WIDTH-1:0] w);
      logic [NBYTES*8-1:0] pad;
      logic [7:0]          c;
      pad = '0;
      pad[DATA_WIDTH-1:0] = w;
      c = crc;
      for (int b = 0; b < NBYTES; b++) begin
         c = crc8_step(c, pad[b*8 +: 8]);
      end
      return c;
   endfunction

   assign crc_rd_next = crc_word(crc_rd, ram_rdata);
   assign crc_match   = (crc_rd_next == crc_wr);
   assign load_err    = load_err_q;
   assign unused_sig  = ^hold_count;
`else
   assign load_err    = 1'b0;
   assign unused_sig  = ^{hold_count, ram_rdata, last_addr};
`endif

   selftest_cycle_timer #(.LIMIT(RESET_CYCLES)) u_hold_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (state != ST_CPURST),
      .enable (state == ST_CPURST),
      .count  (hold_count),
      .last   (hold_last)
   );

   selftest_cycle_timer #(.LIMIT(MAX_CYCLES)) u_run_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (start_accept),
      .enable ((state == ST_RUN) && !cpu_halt),
      .count  (cycles),
      .last   (run_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state   = state;
      ld_ready     = 1'b0;
      xfer         = 1'b0;
      start_accept = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            start_accept = start;
            if (start) next_state = ST_LOAD;
         end
         ST_LOAD: begin
            ld_ready = 1'b1;
            xfer     = ld_valid;
            // The top address ends the load even without ld_last, so it never wraps.
            if (ld_valid && (ld_last || wr_ptr == ADDR_MAX)) next_state = POST_LOAD;
         end
`ifdef SELFTEST_READBACK_EN
         ST_VERIFY: begin
            if (rd_vld_p1 && rd_last_p1) next_state = crc_match ? ST_CPURST : ST_DONE;
         end
`endif
         ST_CPURST: begin
            if (hold_last) next_state = ST_RUN;
         end
         ST_RUN: begin
            // Halt takes priority over a coincident budget expiry.
            if (cpu_halt)      next_state = ST_CHECK;
            else if (run_last) next_state = ST_DONE;
         end
         ST_CHECK: next_state = ST_DONE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_reset  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         timeout    <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         captured   <= '0;
         expected_q <= '0;
         wr_ptr     <= '0;
         last_addr  <= '0;
      end else begin
         cpu_reset <= (next_state != ST_RUN);
         busy      <= !(next_state inside {ST_IDLE, ST_DONE});
         done      <= (next_state == ST_DONE);
         ram_we    <= 1'b0;
         if (start_accept) begin
            expected_q <= expected;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            captured   <= '0;
            wr_ptr     <= '0;
         end
         if (xfer) begin
            ram_we    <= 1'b1;
            ram_addr  <= wr_ptr;
            ram_wdata <= ld_data;
            last_addr <= wr_ptr;
            if (wr_ptr != ADDR_MAX) wr_ptr <= wr_ptr + 1'b1;
         end
`ifdef SELFTEST_READBACK_EN
         if (state == ST_VERIFY && issuing) ram_addr <= rd_ptr;
         if (state == ST_VERIFY && next_state == ST_DONE) pass <= 1'b0;
`endif
         if (state == ST_RUN && next_state == ST_DONE) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
         end
         if (state == ST_CHECK) begin
            captured <= probe;
            pass     <= (probe == expected_q);
         end
      end
   end

`ifdef SELFTEST_READBACK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         load_err_q <= 1'b0;
         crc_wr     <= '0;
         crc_rd     <= '0;
         rd_ptr     <= '0;
         issuing    <= 1'b0;
         rd_vld_p0  <= 1'b0;
         rd_last_p0 <= 1'b0;
         rd_vld_p1  <= 1'b0;
         rd_last_p1 <= 1'b0;
      end else begin
         if (start_accept) begin
            load_err_q <= 1'b0;
            crc_wr     <= '0;
         end
         if (xfer) crc_wr <= crc_word(crc_wr, ld_data);
         if (state == ST_LOAD && next_state == ST_VERIFY) begin
            rd_ptr  <= '0;
            issuing <= 1'b1;
            crc_rd  <= '0;
         end
         // p0: read address on the RAM port
         rd_vld_p0  <= 1'b0;
         rd_last_p0 <= 1'b0;
         if (state == ST_VERIFY && issuing) begin
            rd_vld_p0  <= 1'b1;
            rd_last_p0 <= (rd_ptr == last_addr);
            if (rd_ptr == last_addr) issuing <= 1'b0;
            else                     rd_ptr  <= rd_ptr + 1'b1;
         end
         // p1: read data on ram_rdata
         rd_vld_p1  <= rd_vld_p0;
         rd_last_p1 <= rd_last_p0;
         if (rd_vld_p1) crc_rd <= crc_rd_next;
         if (state == ST_VERIFY && next_state == ST_DONE) load_err_q <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_selftest_sequencer.sv
// Bench for selftest_sequencer: RAM and tiny CPU stub, directed plus randomized images.
module tb_selftest_sequencer;

   localparam int DW   = 8;
   localparam int AW   = 4;
   localparam int MAXC = 50;
   localparam int RSTC = 2;
   localparam int CW   = $clog2(MAXC + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] expected = '0;
   logic          ld_valid = 1'b0;
   logic          ld_ready;
   logic [DW-1:0] ld_data = '0;
   logic          ld_last = 1'b0;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata = '0;
   logic          cpu_reset;
   logic          cpu_halt = 1'b0;
   logic [DW-1:0] probe;
   logic          busy, done, pass, timeout, load_err;
   logic [CW-1:0] cycles;
   logic [DW-1:0] captured;

   selftest_sequencer #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_CYCLES(MAXC), .RESET_CYCLES(RSTC)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .expected(expected),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .cpu_reset(cpu_reset), .cpu_halt(cpu_halt), .probe(probe),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout), .load_err(load_err),
      .cycles(cycles), .captured(captured)
   );

   always #5 clk = ~clk;

   // Synchronous RAM with optional read corruption at address 3.
   logic [7:0] mem [16] = '{default: 8'h00};
   bit         corrupt = 1'b0;
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= (corrupt && ram_addr == 4'd3) ? (mem[ram_addr] ^ 8'h01) : mem[ram_addr];
   end

   // CPU stub: one instruction per cycle, 0x5n = LDI n, 0xFx = HLT, else NOP.
   logic [3:0] pc = '0;
   logic [7:0] acc = '0;
   assign probe = acc;
   always @(posedge clk) begin
      if (cpu_reset) begin
         pc <= '0; acc <= '0; cpu_halt <= 1'b0;
      end else if (!cpu_halt) begin
         case (mem[pc][7:4])
            4'h5: acc <= {4'h0, mem[pc][3:0]};
            4'hF: cpu_halt <= 1'b1;
            default: ;
         endcase
         pc <= pc + 4'd1;
      end
   end

   // Event monitor, sampled shortly after each rising edge.
   int cyc = 0, halt_cyc = -1, done_cyc = -1;
   bit released = 1'b0;
   always begin
      @(posedge clk);
      #2;
      cyc++;
      if (start) begin
         halt_cyc = -1; done_cyc = -1; released = 1'b0;
      end else begin
         if (cpu_halt && !cpu_reset && halt_cyc < 0) halt_cyc = cyc;
         if (done && done_cyc < 0) done_cyc = cyc;
         if (!cpu_reset) released = 1'b1;
      end
   end

   int vectors = 0, errs = 0;
   logic [7:0] img [17];
   logic [7:0] ref_mem [16] = '{default: 8'h00};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: CPU runs from RAM image; halt visible the cycle after HLT executes.
   task automatic model(output bit halted, output int cyc_exp, output logic [7:0] acc_exp);
      logic [7:0] w;
      halted = 1'b0; cyc_exp = MAXC; acc_exp = 8'h00;
      for (int j = 0; j < MAXC - 1; j++) begin
         w = ref_mem[j % 16];
         if (w[7:4] == 4'h5) acc_exp = {4'h0, w[3:0]};
         else if (w[7:4] == 4'hF) begin
            halted = 1'b1; cyc_exp = j + 1; break;
         end
      end
   endtask

   task automatic do_start(input logic [7:0] expv);
      @(negedge clk); start = 1'b1; expected = expv;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic load_image(input int n_offer, input bit use_last, output int acc_cnt);
      int i, guard;
      bit rdy;
      i = 0; guard = 0; acc_cnt = 0;
      while (i < n_offer && guard < n_offer + 6) begin
         @(negedge clk);
         rdy      = ld_ready;
         ld_valid = 1'b1;
         ld_data  = img[i];
         ld_last  = use_last && (i == n_offer - 1);
         @(posedge clk);
         if (rdy) begin i++; acc_cnt++; end
         guard++;
      end
      @(negedge clk); ld_valid = 1'b0; ld_last = 1'b0;
   endtask

   task automatic run_case(input string tag, input int len, input int n_offer, input bit use_last,
                           input bit want_pass, input bit exp_lerr);
      bit halted; int cyc_exp; logic [7:0] acc_exp, expv; int acc_cnt, n, bad;
      for (int i = 0; i < len; i++) ref_mem[i] = img[i];
      model(halted, cyc_exp, acc_exp);
      expv = want_pass ? acc_exp : (acc_exp ^ 8'h01);
      do_start(expv);
      check({tag, "_busy"}, busy, 1);
      load_image(n_offer, use_last, acc_cnt);
      check({tag, "_beats"}, acc_cnt, len);
      n = 0;
      while (!done && n < 400) begin @(negedge clk); n++; end
      check({tag, "_done"}, done, 1);
      check({tag, "_idle"}, {busy, cpu_reset, load_err}, {1'b0, 1'b1, exp_lerr});
      bad = 0;
      for (int i = 0; i < len; i++) if (mem[i] !== img[i]) bad++;
      check({tag, "_ram"}, bad, 0);
      if (exp_lerr) begin
         check({tag, "_pass"}, pass, 0);
         check({tag, "_released"}, released, 0);
      end else begin
         check({tag, "_timeout"}, timeout, !halted);
         check({tag, "_pass"}, pass, halted && want_pass);
         check({tag, "_cycles"}, cycles, cyc_exp);
         if (halted) begin
            check({tag, "_captured"}, captured, acc_exp);
            check({tag, "_halt_lat"}, done_cyc - halt_cyc, 2);
         end
      end
   endtask

   initial begin
      int len, n_offer, p, q, n;
      bit use_last;
      repeat (3) @(negedge clk);
      check("rst_ctl", {ld_ready, ram_we, busy, done, pass, timeout, load_err, cpu_reset}, 8'h01);
      check("rst_data", {ram_addr, ram_wdata, cycles, captured}, 0);
      @(negedge clk); reset = 1'b0;

      img[0] = 8'h58; img[1] = 8'hF0;
      run_case("ldi_ok", 2, 2, 1, 1, 0);
      check("ldi_ok_val", captured, 8'h08);
      run_case("ldi_bad", 2, 2, 1, 0, 0);
      check("ldi_bad_val", {pass, captured}, {1'b0, 8'h08});

      img[0] = 8'h01; img[1] = 8'h02;
      run_case("nohlt", 2, 2, 1, 1, 0);
      check("nohlt_to", {timeout, pass, cycles}, {1'b1, 1'b0, CW'(MAXC)});

      for (int i = 0; i < 17; i++) img[i] = 8'h00;
      img[9] = 8'h53; img[12] = 8'hF0;
      run_case("full16", 16, 17, 0, 1, 0);
      check("full16_rdy", ld_ready, 0);

      for (int i = 0; i < 7; i++) img[i] = 8'h00;
      img[5] = 8'h57; img[6] = 8'hF0;
      for (int i = 0; i < 7; i++) ref_mem[i] = img[i];
      do_start(8'h07);
      begin
         int acc_cnt;
         load_image(7, 1, acc_cnt);
      end
      n = 0;
      while (cpu_reset && n < 100) begin @(negedge clk); n++; end
      @(negedge clk); @(negedge clk);
      check("midrun_busy", {busy, cpu_reset}, 2'b10);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      check("midrst_ctl", {ld_ready, ram_we, busy, done, pass, timeout, load_err, cpu_reset}, 8'h01);
      check("midrst_data", {ram_addr, ram_wdata, cycles, captured}, 0);
      run_case("rerun", 7, 7, 1, 1, 0);

`ifdef SELFTEST_READBACK_EN
      for (int i = 0; i < 6; i++) img[i] = 8'h20 + 8'(i);
      img[4] = 8'h56; img[5] = 8'hF0;
      corrupt = 1'b1;
      run_case("rb_err", 6, 6, 1, 1, 1);
      corrupt = 1'b0;
`endif

      for (int t = 0; t < 24; t++) begin
         len = $urandom_range(1, 16);
         for (int i = 0; i < 17; i++) img[i] = 8'($urandom_range(0, 255));
         if (len >= 2 && $urandom_range(0, 3) != 0) begin
            p = $urandom_range(0, len - 2);
            q = $urandom_range(p + 1, len - 1);
            img[p] = 8'h50 | 8'($urandom_range(0, 15));
            img[q] = 8'hF0;
         end
         use_last = (len < 16) ? 1'b1 : 1'($urandom_range(0, 1));
         n_offer  = len;
         run_case($sformatf("rnd%0d", t), len, n_offer, use_last, 1'($urandom_range(0, 1)), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
